// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, command bytes and filter depth.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    START,
    DATA,
    STOP,
    ACK,
    RELEASE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  localparam int PS2_FILTER_LEN = 8;

endpackage

// File: rtl/ps2_line_filter.sv
// Glitch filter for one PS/2 line: the level only changes after FILTER_LEN identical samples.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);

  logic [FILTER_LEN-1:0] sr;
  logic                  level_d1;

  // Idle bus is pulled high, so reset assumes a released line.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr       <= '1;
      level    <= 1'b1;
      level_d1 <= 1'b1;
    end else begin
      sr       <= {sr[FILTER_LEN-2:0], line};
      level_d1 <= level;
      if (&sr) begin
        level <= 1'b1;
      end else if (~|sr) begin
        level <= 1'b0;
      end
    end
  end

  assign fall = level_d1 & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits LSB first, odd parity, stop, ACK check.
// Optional device-silence watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int RTS_CYCLES     = 12000,
  parameter int FILTER_LEN     = PS2_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err
);

  localparam int RTS_W = $clog2(RTS_CYCLES + 1);

  ps2_tx_state_t    state_q, state_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       n_q, n_d;
  logic [RTS_W-1:0] rts_q, rts_d;
  logic             ack_err_d, done_d;

  logic c_lvl, c_fall, d_lvl, d_fall_unused;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
    .clk   (clk),
    .reset (reset),
    .line  (ps2c),
    .level (c_lvl),
    .fall  (c_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
    .clk   (clk),
    .reset (reset),
    .line  (ps2d),
    .level (d_lvl),
    .fall  (d_fall_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      n_q          <= '0;
      rts_q        <= '0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      ack_err      <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      n_q          <= n_d;
      rts_q        <= rts_d;
      tx_idle      <= (state_d == IDLE);
      tx_done_tick <= done_d;
      ack_err      <= ack_err_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    n_d       = n_q;
    rts_d     = rts_q;
    ack_err_d = ack_err;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_ps2) begin
          shift_d = {~^din, din};
          rts_d   = RTS_W'(RTS_CYCLES - 1);
          state_d = RTS;
        end
      end
      RTS: begin
        if (rts_q == '0) begin
          state_d = START;
        end else begin
          rts_d = rts_q - RTS_W'(1);
        end
      end
      START: begin
        if (c_fall) begin
          n_d     = 4'd8;
          state_d = DATA;
        end
      end
      // Shift only on a fall so the bit is stable across the device's rising-edge sample.
      DATA: begin
        if (c_fall) begin
          shift_d = {1'b0, shift_q[8:1]};
          if (n_q == 4'd0) begin
            state_d = STOP;
          end else begin
            n_d = n_q - 4'd1;
          end
        end
      end
      STOP: begin
        if (c_fall) begin
          state_d = ACK;
        end
      end
      ACK: begin
        if (c_fall) begin
          ack_err_d = d_lvl;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (c_lvl && d_lvl) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    wd_d = '0;
    if (state_q inside {START, DATA, STOP, ACK, RELEASE}) begin
      if (wd_q == WD_W'(TIMEOUT_CYCLES)) begin
        state_d   = IDLE;
        ack_err_d = 1'b1;
        done_d    = 1'b1;
      end else if (!c_fall) begin
        wd_d = wd_q + WD_W'(1);
      end
    end
`endif
  end

  // Open-drain: only ever pull low or release.
  assign ps2c = (state_q == RTS) ? 1'b0 : 1'bz;
  assign ps2d = ((state_q == START) || ((state_q == DATA) && !shift_q[0])) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model.
module tb_ps2_host_tx;

  localparam int RTS  = 40;
  localparam int HALF = 20;
  localparam int TMO  = 400;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  wire        ps2c;
  wire        ps2d;
  logic       dev_c;
  logic       dev_d;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       ack_err;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int d0;
  int low;
  logic [10:0] frame;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c ? 1'bz : 1'b0;
  assign ps2d = dev_d ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .RTS_CYCLES     (RTS),
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .ack_err      (ack_err)
  );

  always @(negedge clk) if (tx_done_tick === 1'b1) done_cnt++;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    din    = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  // Device side: samples ps2d just before pulling the clock low, so the frame
  // collects start, 8 data bits, parity and stop in order.
  task automatic device_xfer(input bit do_ack, input int n_falls, input bit glitch,
                             output logic [10:0] fr, output int low_len);
    int w;
    fr = '1;
    w  = 0;
    while (ps2c !== 1'b0 && w < 200) begin
      w++;
      @(negedge clk);
    end
    check("rts_seen", {31'd0, ps2c === 1'b0}, 32'd1);
    low_len = 0;
    while (ps2c === 1'b0 && low_len < 5000) begin
      low_len++;
      @(negedge clk);
    end
    cycles(30);
    for (int k = 0; k < n_falls; k++) begin
      if (k < 11) fr[k] = ps2d;
      dev_c = 1'b0;
      cycles(HALF);
      dev_c = 1'b1;
      if (k == 11) dev_d = 1'b1;
      if (k == 10 && do_ack) dev_d = 1'b0;
      if (glitch && k < 10) begin
        cycles(12);
        dev_c = 1'b0;
        cycles(3);
        dev_c = 1'b1;
        cycles(HALF - 15);
      end else begin
        cycles(HALF);
      end
    end
    dev_d = 1'b1;
  endtask

  initial begin
    reset  = 1'b1;
    wr_ps2 = 1'b0;
    din    = 8'h00;
    dev_c  = 1'b1;
    dev_d  = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(12);

    check("rst_idle", {31'd0, tx_idle}, 32'd1);
    check("rst_done", {31'd0, tx_done_tick}, 32'd0);
    check("rst_ackerr", {31'd0, ack_err}, 32'd0);
    check("rst_ps2c", {31'd0, ps2c}, 32'd1);
    check("rst_ps2d", {31'd0, ps2d}, 32'd1);

    // ED with ACK: frame {stop=1, par=1, ED, start=0}
    d0 = done_cnt;
    send(8'hED);
    check("ed_idle_fall", {31'd0, tx_idle}, 32'd0);
    device_xfer(1'b1, 12, 1'b0, frame, low);
    cycles(40);
    check("ed_rts_len", low, RTS);
    check("ed_frame", {21'd0, frame}, 32'h7DA);
    check("ed_done", done_cnt - d0, 32'd1);
    check("ed_ackerr", {31'd0, ack_err}, 32'd0);
    check("ed_idle", {31'd0, tx_idle}, 32'd1);

    // F4: parity 0
    d0 = done_cnt;
    send(8'hF4);
    device_xfer(1'b1, 12, 1'b0, frame, low);
    cycles(40);
    check("f4_frame", {21'd0, frame}, 32'h5E8);
    check("f4_ackerr", {31'd0, ack_err}, 32'd0);
    check("f4_done", done_cnt - d0, 32'd1);

    // 00 without device ACK
    d0 = done_cnt;
    send(8'h00);
    device_xfer(1'b0, 12, 1'b0, frame, low);
    cycles(40);
    check("00_frame", {21'd0, frame}, 32'h600);
    check("00_ackerr", {31'd0, ack_err}, 32'd1);
    check("00_done", done_cnt - d0, 32'd1);

    // Reset mid-DATA after 4 falls; F4 has din[3]=0 so data is being pulled low
    d0 = done_cnt;
    send(8'hF4);
    device_xfer(1'b1, 4, 1'b0, frame, low);
    check("pre_reset_d", {31'd0, ps2d}, 32'd0);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("mid_rst_idle", {31'd0, tx_idle}, 32'd1);
    check("mid_rst_ps2c", {31'd0, ps2c}, 32'd1);
    check("mid_rst_ps2d", {31'd0, ps2d}, 32'd1);
    check("mid_rst_ackerr", {31'd0, ack_err}, 32'd0);
    cycles(20);
    check("mid_rst_done", done_cnt - d0, 32'd0);

    d0 = done_cnt;
    send(8'hFF);
    device_xfer(1'b1, 12, 1'b0, frame, low);
    cycles(40);
    check("ff_frame", {21'd0, frame}, 32'h7FE);
    check("ff_ackerr", {31'd0, ack_err}, 32'd0);
    check("ff_done", done_cnt - d0, 32'd1);

    // ED with a stray AA write mid-transfer and short clock glitches
    d0 = done_cnt;
    send(8'hED);
    fork
      device_xfer(1'b1, 12, 1'b1, frame, low);
      begin
        cycles(300);
        din    = 8'hAA;
        wr_ps2 = 1'b1;
        cycles(1);
        wr_ps2 = 1'b0;
      end
    join
    cycles(40);
    check("gl_frame", {21'd0, frame}, 32'h7DA);
    check("gl_ackerr", {31'd0, ack_err}, 32'd0);
    check("gl_done", done_cnt - d0, 32'd1);
    cycles(100);
    check("gl_no_queue", {31'd0, ps2c}, 32'd1);
    check("gl_idle", {31'd0, tx_idle}, 32'd1);

    // Device-initiated clocks while idle
    d0 = done_cnt;
    dev_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dev_c = 1'b0;
      cycles(HALF);
      dev_c = 1'b1;
      cycles(HALF);
    end
    dev_d = 1'b1;
    cycles(20);
    check("dev_idle", {31'd0, tx_idle}, 32'd1);
    check("dev_done", done_cnt - d0, 32'd0);

    // Write and reset in the same cycle: reset wins
    @(negedge clk);
    reset  = 1'b1;
    wr_ps2 = 1'b1;
    din    = 8'hAA;
    @(negedge clk);
    reset  = 1'b0;
    wr_ps2 = 1'b0;
    cycles(5);
    check("rw_idle", {31'd0, tx_idle}, 32'd1);
    check("rw_ps2c", {31'd0, ps2c}, 32'd1);

`ifdef PS2_TX_TIMEOUT_EN
    // Device stops after 5 falls; watchdog must abort
    d0 = done_cnt;
    send(8'hED);
    device_xfer(1'b1, 5, 1'b0, frame, low);
    begin
      int w;
      w = 0;
      while (done_cnt == d0 && w < 2000) begin
        w++;
        @(negedge clk);
      end
    end
    cycles(2);
    check("tmo_done", done_cnt - d0, 32'd1);
    check("tmo_ackerr", {31'd0, ack_err}, 32'd1);
    check("tmo_idle", {31'd0, tx_idle}, 32'd1);
    check("tmo_ps2c", {31'd0, ps2c}, 32'd1);
    check("tmo_ps2d", {31'd0, ps2d}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
